// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction ROM.
//   imem_addr  : word address, driven by the fetch stage
//   imem_rdata : instruction word, combinational read of imem_addr
// Modports: master = fetch stage, slave = ROM.
interface fetch_stage_if #(
    parameter int IMEM_AW = 8
) ();
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register for the MIPS datapath.
// Holds the PC, drives the instruction ROM address, latches the fetched word
// into IF/ID and exposes its opcode to control. Branches and jumps resolve in
// ID; a taken redirect replaces the wrong-path fetch with a single bubble.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           freezes PC and IF/ID (a pending redirect is re-evaluated later)
//   beq, bne, jump  control decode of the instruction in ID
//   zero            ID comparator result (rs == rt)
//   imem            instruction-memory bus (master side)
//   pc              current fetch PC
//   if_id_instr     IF/ID instruction, if_id_pc4 its PC+4, if_id_valid slot is real
//   opcode          if_id_instr[31:26]
//   fetch_count,    (FETCH_STATS_EN only) counts of fetch edges and flush edges,
//   flush_count     both wrapping and holding while stalled
//
// Build option: define FETCH_STATS_EN to add the two statistics counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          beq,
    input  logic          bne,
    input  logic          jump,
    input  logic          zero,
    fetch_stage_if.master imem,
    output logic [31:0]   pc,
    output logic [31:0]   if_id_instr,
    output logic [31:0]   if_id_pc4,
    output logic          if_id_valid,
    output logic [5:0]    opcode
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   flush_count
`endif
);

    // IDLE: IF/ID holds a bubble (after reset or a flush). RUN: IF/ID is real.
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic        do_fetch, do_flush;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] br_target, j_target, target;

    assign if_id_valid    = (state == RUN);
    assign opcode         = if_id_instr[31:26];
    assign imem.imem_addr = pc[IMEM_AW+1:2];   // ROM aliases on the upper PC bits

    assign pc_plus4  = pc + 32'd4;
    assign br_target = if_id_pc4 + {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
    assign j_target  = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    assign target    = jump ? j_target : br_target;

    // A bubble in ID never redirects, whatever control happens to say.
    assign taken = if_id_valid & ((beq & zero) | (bne & ~zero) | jump);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stall outranks the redirect: the branch stays in ID and is re-evaluated.
    always_comb begin
        state_nxt = state;
        do_fetch  = 1'b0;
        do_flush  = 1'b0;
        if (!stall) begin
            if (taken) begin
                do_flush  = 1'b1;
                state_nxt = IDLE;
            end else begin
                do_fetch  = 1'b1;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else if (do_flush) begin
            pc          <= target;
            if_id_instr <= 32'h0;   // sll $0 NOP, opcode reads 0
            if_id_pc4   <= 32'h0;
        end else if (do_fetch) begin
            pc          <= pc_plus4;
            if_id_instr <= imem.imem_rdata;
            if_id_pc4   <= pc_plus4;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (do_fetch) fetch_count <= fetch_count + 32'd1;
            if (do_flush) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0, beq = 1'b0, bne = 1'b0, jump = 1'b0, zero = 1'b0;

    always #5 clk = ~clk;

    // dut1: main instance; dut2: high reset PC for the jump-region test;
    // dut3: reset PC near the top of the address space for the wrap test.
    fetch_stage_if #(.IMEM_AW(8)) bus1 ();
    fetch_stage_if #(.IMEM_AW(8)) bus2 ();
    fetch_stage_if #(.IMEM_AW(8)) bus3 ();

    logic [31:0] rom [256];
    assign bus1.imem_rdata = rom[bus1.imem_addr];
    assign bus2.imem_rdata = (bus2.imem_addr == 8'd3) ? 32'h0800_0040 : 32'h2400_0000;
    assign bus3.imem_rdata = rom[bus3.imem_addr];

    logic [31:0] pc1, instr1, pc41, pc2, instr2, pc42, pc3, instr3, pc43;
    logic        valid1, valid2, valid3;
    logic [5:0]  op1, op2, op3;
`ifdef FETCH_STATS_EN
    logic [31:0] fc1, fl1, fc2, fl2, fc3, fl3;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
        .imem(bus1), .pc(pc1), .if_id_instr(instr1), .if_id_pc4(pc41),
        .if_id_valid(valid1), .opcode(op1)
`ifdef FETCH_STATS_EN
        , .fetch_count(fc1), .flush_count(fl1)
`endif
    );

    fetch_stage #(.RESET_PC(32'h1000_000C), .IMEM_AW(8)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
        .imem(bus2), .pc(pc2), .if_id_instr(instr2), .if_id_pc4(pc42),
        .if_id_valid(valid2), .opcode(op2)
`ifdef FETCH_STATS_EN
        , .fetch_count(fc2), .flush_count(fl2)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(8)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .beq(beq), .bne(bne), .jump(jump), .zero(zero),
        .imem(bus3), .pc(pc3), .if_id_instr(instr3), .if_id_pc4(pc43),
        .if_id_valid(valid3), .opcode(op3)
`ifdef FETCH_STATS_EN
        , .fetch_count(fc3), .flush_count(fl3)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic s, input logic b, input logic n, input logic j, input logic z);
        stall = s; beq = b; bne = n; jump = j; zero = z;
    endtask

    // Assert reset away from an edge, check the async values, release on a negedge.
    task automatic do_reset();
        @(negedge clk);
        set_ctrl(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_pc1",    pc1,    32'h0);
        check("rst_valid1", {31'h0, valid1}, 32'h0);
        check("rst_instr1", instr1, 32'h0);
        check("rst_pc4_1",  pc41,   32'h0);
        check("rst_op1",    {26'h0, op1}, 32'h0);
        check("rst_pc2",    pc2,    32'h1000_000C);
        check("rst_pc3",    pc3,    32'hFFFF_FFF8);
`ifdef FETCH_STATS_EN
        check("rst_fc1", fc1, 32'h0);
        check("rst_fl1", fl1, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall, beq, bne, jump, zero;
        logic [31:0] pc, instr, pc4;
        logic        valid;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic n, input logic j,
                                input logic z, input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] p4, input logic v);
        vec_t r;
        r.stall = s; r.beq = b; r.bne = n; r.jump = j; r.zero = z;
        r.pc = p; r.instr = i; r.pc4 = p4; r.valid = v;
        return r;
    endfunction

    vec_t vecs [16];
    vec_t sb [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        logic [5:0] exp_op;

        for (int i = 0; i < 256; i++) rom[i] = 32'h2400_0000 | i;
        rom[0] = 32'h8C01_0004;   // lw
        rom[1] = 32'h1022_0003;   // beq imm 3
        rom[2] = 32'h0800_0001;   // j -> 4
        rom[3] = 32'h1422_FFFE;   // bne imm -2
        rom[5] = 32'h1022_0003;   // beq imm 3
        rom[6] = 32'h0800_0003;   // j -> 12

        //               st b  n  j  z  pc             instr          pc4            v
        vecs[0]  = mk(0, 0, 0, 0, 0, 32'd4,  32'h8C01_0004, 32'd4,  1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'd8,  32'h1022_0003, 32'd8,  1);
        vecs[2]  = mk(0, 1, 0, 0, 1, 32'd20, 32'h0,         32'd0,  0); // beq taken
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'd24, 32'h1022_0003, 32'd24, 1);
        vecs[4]  = mk(0, 1, 0, 0, 0, 32'd28, 32'h0800_0003, 32'd28, 1); // beq not taken
        vecs[5]  = mk(0, 0, 0, 1, 0, 32'd12, 32'h0,         32'd0,  0); // jump
        vecs[6]  = mk(0, 0, 0, 0, 0, 32'd16, 32'h1422_FFFE, 32'd16, 1);
        vecs[7]  = mk(0, 0, 1, 0, 0, 32'd8,  32'h0,         32'd0,  0); // bne backward
        vecs[8]  = mk(0, 0, 0, 1, 0, 32'd12, 32'h0800_0001, 32'd12, 1); // jump on bubble ignored
        vecs[9]  = mk(1, 0, 0, 0, 0, 32'd12, 32'h0800_0001, 32'd12, 1); // stall
        vecs[10] = mk(1, 0, 0, 1, 0, 32'd12, 32'h0800_0001, 32'd12, 1); // stall beats jump
        vecs[11] = mk(0, 0, 0, 1, 0, 32'd4,  32'h0,         32'd0,  0); // deferred jump
        vecs[12] = mk(1, 0, 0, 0, 0, 32'd4,  32'h0,         32'd0,  0); // stall in bubble
        vecs[13] = mk(0, 0, 0, 0, 0, 32'd8,  32'h1022_0003, 32'd8,  1);
        vecs[14] = mk(0, 0, 1, 0, 1, 32'd12, 32'h0800_0001, 32'd12, 1); // bne not taken
        vecs[15] = mk(0, 1, 0, 1, 1, 32'd4,  32'h0,         32'd0,  0); // jump beats beq

        // Reset, first fetch and straight-line fetch; dut3 wraps past 2^32.
        do_reset();
        step();
        check("t1_instr", instr1, 32'h8C01_0004);
        check("t1_pc4",   pc41,   32'd4);
        check("t1_valid", {31'h0, valid1}, 32'h1);
        check("t1_op",    {26'h0, op1}, 32'h23);
        check("t1_pc",    pc1,    32'd4);
        check("wrap_pc_a", pc3,   32'hFFFF_FFFC);
        step();
        check("wrap_pc_b",  pc3,  32'h0);
        check("wrap_pc4",   pc43, 32'h0);
        check("wrap_instr", instr3, rom[8'hFF]);
        for (int i = 0; i < 3; i++) step();
        check("t2_pc",  pc1,  32'd20);
        check("t2_pc4", pc41, 32'd20);
`ifdef FETCH_STATS_EN
        check("t2_fc", fc1, 32'd5);
`endif

        // Jump out of a high PC region, first held off by a stall.
        do_reset();
        check("t5_alias", {24'h0, bus2.imem_addr}, 32'd3);
        step();
        check("t5_pc4", pc42, 32'h1000_0010);
        set_ctrl(1, 0, 0, 1, 0);
        step();
        check("t5_stall_pc",    pc2,  32'h1000_0010);
        check("t5_stall_pc4",   pc42, 32'h1000_0010);
        check("t5_stall_valid", {31'h0, valid2}, 32'h1);
        set_ctrl(0, 0, 0, 1, 0);
        step();
        check("t5_jump_pc",    pc2, 32'h1000_0100);
        check("t5_jump_valid", {31'h0, valid2}, 32'h0);

        // Table run through the scoreboard.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_ctrl(vecs[i].stall, vecs[i].beq, vecs[i].bne, vecs[i].jump, vecs[i].zero);
            sb.push_back(vecs[i]);
            step();
            if (sb.size() == 0) begin
                check("sb_empty", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                exp_op = e.instr[31:26];
                check($sformatf("v%0d_pc", i),    pc1,    e.pc);
                check($sformatf("v%0d_instr", i), instr1, e.instr);
                check($sformatf("v%0d_pc4", i),   pc41,   e.pc4);
                check($sformatf("v%0d_valid", i), {31'h0, valid1}, {31'h0, e.valid});
                check($sformatf("v%0d_op", i),    {26'h0, op1}, {26'h0, exp_op});
            end
        end
`ifdef FETCH_STATS_EN
        check("tbl_fc", fc1, 32'd8);
        check("tbl_fl", fl1, 32'd5);
`endif

        // Asynchronous reset between edges.
        set_ctrl(0, 0, 0, 0, 0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc1",    pc1, 32'h0);
        check("arst_valid1", {31'h0, valid1}, 32'h0);
        check("arst_instr1", instr1, 32'h0);
        check("arst_pc2",    pc2, 32'h1000_000C);
`ifdef FETCH_STATS_EN
        check("arst_fc1", fc1, 32'h0);
        check("arst_fl1", fl1, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
